phy_tx_sequencer: RTL and testbench
===================================

PHY_TX_SEQUENCER -- requirements
Module: phy_tx_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk, input, 1, rising-edge clock; rst_n, input, 1, asynchronous active-low reset.
REQ-002 tx_start  input  1  one-cycle frame request, honoured only in IDLE.
REQ-003 tx_sop_type  input  2  0=SOP, 1=SOP', 2=SOP'', 3=Hard Reset; sampled with tx_start.
REQ-004 tx_byte  input  8  payload byte (header plus data).
REQ-005 tx_byte_valid / tx_byte_last  input  1 each  byte valid; marks final payload byte.
REQ-006 tx_byte_ready  output  1  byte accepted on a cycle with valid&&ready.
REQ-007 tx_busy  output  1  high from tx_start until tx_done; tx_done  output  1  one-cycle end pulse; tx_underrun  output  1  one-cycle abort pulse.
REQ-008 phy_bmc_encoder_data  output  5  symbol; bit0 is sent first.
REQ-009 phy_bmc_encoder_data_en / phy_bmc_encoder_data_preamble  output  1 each  symbol present; preamble symbol.
REQ-010 phy_bmc_encoder_data_done / phy_bmc_encoder_hold_lowbmc_done  input  1 each  symbol-accepted pulse; line-release pulse.

Function
REQ-011 Symbol codes are listed with the first-sent bit (bit0) leftmost.
- Nibbles 0-F: 11110 01001 10100 10101 01010 01011 01110 01111 10010 10011 10110 10111 11010 11011 11100 11101.
- Sync-1 11000, Sync-2 10001, Sync-3 00110, RST-1 00111, RST-2 11001, EOP 01101.
REQ-012 States: IDLE, PRE, SOP, DATA, CRC, EOP, HOLD.
REQ-013 IDLE + tx_start:
- Latch tx_sop_type.
- Drive data=0, preamble=1, data_en=1.
- Clear the CRC to 0xFFFFFFFF.
- Go to PRE.
REQ-014 data_en stays high from PRE through EOP. A new symbol is registered on the edge where data_done=1, and held stable until the next data_done.
REQ-015 PRE: on data_done, preamble goes to 0, the first ordered-set symbol is loaded, and the state goes to SOP.
REQ-016 Ordered sets:
- SOP = S1 S1 S1 S2.
- SOP' = S1 S1 S3 S3.
- SOP'' = S1 S3 S1 S3.
- Hard Reset = R1 R1 R1 R2.
- A 2-bit index counts the symbols.
REQ-017 Hard Reset: after the 4th K-code's data_done, data_en drops, the state goes to HOLD, and tx_byte_ready never asserts.
REQ-018 1-byte holding register:
- tx_byte_ready = holding register empty && state in {PRE, SOP, DATA} && last byte not yet accepted && type!=3.
- On valid&&ready, the byte is captured and the CRC is updated over that byte.
REQ-019 DATA sends each byte low nibble first, then high nibble. When a low nibble is due (a data_done while in DATA or at the end of SOP), the sequencer loads it from the holding register and empties the register.
REQ-020 Underrun: holding register empty when a low nibble is due and tx_byte_last not yet accepted ->
- data_en <= 0;
- tx_underrun pulses;
- the state goes to HOLD.
REQ-021 After the data_done for the last byte's high nibble, the state goes to CRC. CRC sends 8 nibbles: byte0..byte3 of ~crc, each low nibble first.
REQ-022 CRC-32 definition:
- Reflected polynomial 0xEDB88320, LSB-first, initial value 0xFFFFFFFF, final complement.
- Computed as a combinational 8-step update in one cycle.
REQ-023 After the data_done for the 8th CRC nibble, EOP is loaded. On the data_done for EOP, data_en drops and the state goes to HOLD.
REQ-024 HOLD: on hold_lowbmc_done, tx_done pulses (also after an underrun), tx_busy drops, and the state goes to IDLE.
REQ-025 tx_start is ignored outside IDLE. tx_byte_valid is ignored while ready=0. data_done in IDLE or HOLD is ignored.

Reset
REQ-026 With rst_n low, all outputs are 0, state=IDLE, the holding register is empty, and CRC=0xFFFFFFFF.
REQ-027 Reset asserted mid-frame aborts immediately to the REQ-026 values, with no tx_done.

Verification
REQ-028 The bench uses an encoder model that pulses data_done 1 cycle after accept, with accepts 40 cycles apart (preamble: 512), and hold_lowbmc_done 24 cycles after data_en falls.
- Scenario 1: type 0, bytes 0xA1,0x61(last) -> preamble, S1 S1 S1 S2, nibbles 1,A,1,6, 8 CRC nibbles, EOP, then one tx_done.
- Scenario 2: type 0, bytes ASCII "123456789" -> CRC nibbles 6,2,9,3,4,F,B,C (0xCBF43926).
- Scenario 3: type 3 -> preamble, R1 R1 R1 R2, data_en falls, tx_byte_ready stays 0, tx_done after hold_lowbmc_done.
- Scenario 4: type 1, one byte given, then valid withheld -> S1 S1 S3 S3, 2 nibbles, tx_underrun pulse, data_en 0, later tx_done.
- Scenario 5: tx_start re-pulsed mid-frame -> ignored; rst_n low mid-DATA -> all outputs 0 asynchronously; a following frame is correct.
- Scenario 6: type 2 -> S1 S3 S1 S3; tx_byte_valid held high continuously -> exactly one byte accepted per holding-register drain.

Source files
------------

// File: rtl/phy_tx_sequencer_if.sv
// Handshake bundle between frame source, TX sequencer and BMC encoder; sequencer uses slave.
// Registered symbol outputs; tx_byte_ready/tx_byte_valid and data_done pace the transfer.
interface phy_tx_sequencer_if;
    logic       tx_start;
    logic [1:0] tx_sop_type;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_last;
    logic       tx_byte_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_underrun;
    logic [4:0] phy_bmc_encoder_data;
    logic       phy_bmc_encoder_data_en;
    logic       phy_bmc_encoder_data_preamble;
    logic       phy_bmc_encoder_data_done;
    logic       phy_bmc_encoder_hold_lowbmc_done;

    modport master (
        output tx_start, tx_sop_type, tx_byte, tx_byte_valid, tx_byte_last,
        output phy_bmc_encoder_data_done, phy_bmc_encoder_hold_lowbmc_done,
        input  tx_byte_ready, tx_busy, tx_done, tx_underrun,
        input  phy_bmc_encoder_data, phy_bmc_encoder_data_en, phy_bmc_encoder_data_preamble
    );

    modport slave (
        input  tx_start, tx_sop_type, tx_byte, tx_byte_valid, tx_byte_last,
        input  phy_bmc_encoder_data_done, phy_bmc_encoder_hold_lowbmc_done,
        output tx_byte_ready, tx_busy, tx_done, tx_underrun,
        output phy_bmc_encoder_data, phy_bmc_encoder_data_en, phy_bmc_encoder_data_preamble
    );
endinterface

// File: rtl/phy_tx_sequencer.sv
// USB-PD TX framer: preamble, ordered set, 4b5b payload, CRC-32, EOP; next symbol registered on data_done.
// Backpressure: 1-byte holding register drives tx_byte_ready; an empty register when a low nibble is due aborts.
module phy_tx_sequencer (
    input  logic              clk,
    input  logic              rst_n,
    phy_tx_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_SOP, ST_DATA, ST_CRC, ST_EOP, ST_HOLD
    } state_t;

    // Codes are stored with the first-sent bit in bit0.
    localparam logic [4:0]  K_SYNC1  = 5'b00011;
    localparam logic [4:0]  K_SYNC2  = 5'b10001;
    localparam logic [4:0]  K_SYNC3  = 5'b01100;
    localparam logic [4:0]  K_RST1   = 5'b11100;
    localparam logic [4:0]  K_RST2   = 5'b10011;
    localparam logic [4:0]  K_EOP    = 5'b10110;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    function automatic logic [4:0] nib_sym(input logic [3:0] n);
        logic [4:0] s;
        case (n)
            4'h0: s = 5'b01111;  4'h1: s = 5'b10010;
            4'h2: s = 5'b00101;  4'h3: s = 5'b10101;
            4'h4: s = 5'b01010;  4'h5: s = 5'b11010;
            4'h6: s = 5'b01110;  4'h7: s = 5'b11110;
            4'h8: s = 5'b01001;  4'h9: s = 5'b11001;
            4'hA: s = 5'b01101;  4'hB: s = 5'b11101;
            4'hC: s = 5'b01011;  4'hD: s = 5'b11011;
            4'hE: s = 5'b00111;  default: s = 5'b10111;
        endcase
        return s;
    endfunction

    function automatic logic [4:0] os_sym(input logic [1:0] t, input logic [1:0] idx);
        logic [4:0] s;
        case (t)
            2'd0:    s = (idx == 2'd3) ? K_SYNC2 : K_SYNC1;
            2'd1:    s = (idx[1])      ? K_SYNC3 : K_SYNC1;
            2'd2:    s = (idx[0])      ? K_SYNC3 : K_SYNC1;
            default: s = (idx == 2'd3) ? K_RST2  : K_RST1;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [1:0]  os_idx_q, os_idx_d;
    logic [2:0]  crc_idx_q, crc_idx_d;
    logic [31:0] crc_q, crc_d;
    logic        hold_vld_q, hold_vld_d;
    logic [7:0]  hold_dat_q, hold_dat_d;
    logic        hold_last_q, hold_last_d;
    logic        last_acc_q, last_acc_d;
    logic [3:0]  cur_hi_q, cur_hi_d;
    logic        cur_last_q, cur_last_d;
    logic        nib_hi_q, nib_hi_d;
    logic [4:0]  sym_q, sym_d;
    logic        en_q, en_d;
    logic        pre_q, pre_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        underrun_q, underrun_d;

    logic        byte_rdy;
    logic        byte_acc;
    logic        sym_done;
    logic        low_due;
    logic [31:0] crc_fin;
    logic [31:0] crc_sh;
    logic [2:0]  crc_idx_nxt;

    assign byte_rdy    = !hold_vld_q && !last_acc_q && (type_q != 2'd3) &&
                         ((state_q == ST_PRE) || (state_q == ST_SOP) || (state_q == ST_DATA));
    assign byte_acc    = bus.tx_byte_valid && byte_rdy;
    assign sym_done    = bus.phy_bmc_encoder_data_done;
    assign crc_fin     = ~crc_q;
    assign crc_idx_nxt = crc_idx_q + 3'd1;
    assign crc_sh      = crc_fin >> {crc_idx_nxt, 2'b00};

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        os_idx_d    = os_idx_q;
        crc_idx_d   = crc_idx_q;
        crc_d       = crc_q;
        hold_vld_d  = hold_vld_q;
        hold_dat_d  = hold_dat_q;
        hold_last_d = hold_last_q;
        last_acc_d  = last_acc_q;
        cur_hi_d    = cur_hi_q;
        cur_last_d  = cur_last_q;
        nib_hi_d    = nib_hi_q;
        sym_d       = sym_q;
        en_d        = en_q;
        pre_d       = pre_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        low_due     = 1'b0;

        // Capture and drain never coincide: capture needs the register empty, drain needs it full.
        if (byte_acc) begin
            hold_vld_d  = 1'b1;
            hold_dat_d  = bus.tx_byte;
            hold_last_d = bus.tx_byte_last;
            last_acc_d  = last_acc_q | bus.tx_byte_last;
            crc_d       = crc_byte(crc_q, bus.tx_byte);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.tx_start) begin
                    type_d     = bus.tx_sop_type;
                    sym_d      = 5'd0;
                    pre_d      = 1'b1;
                    en_d       = 1'b1;
                    busy_d     = 1'b1;
                    crc_d      = CRC_INIT;
                    hold_vld_d = 1'b0;
                    last_acc_d = 1'b0;
                    cur_last_d = 1'b0;
                    nib_hi_d   = 1'b0;
                    os_idx_d   = 2'd0;
                    state_d    = ST_PRE;
                end
            end
            ST_PRE: begin
                if (sym_done) begin
                    pre_d    = 1'b0;
                    sym_d    = os_sym(type_q, 2'd0);
                    os_idx_d = 2'd0;
                    state_d  = ST_SOP;
                end
            end
            ST_SOP: begin
                if (sym_done) begin
                    if (os_idx_q != 2'd3) begin
                        os_idx_d = os_idx_q + 2'd1;
                        sym_d    = os_sym(type_q, os_idx_q + 2'd1);
                    end else if (type_q == 2'd3) begin
                        en_d    = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        low_due = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (sym_done) begin
                    if (!nib_hi_q) begin
                        sym_d    = nib_sym(cur_hi_q);
                        nib_hi_d = 1'b1;
                    end else if (cur_last_q) begin
                        sym_d     = nib_sym(crc_fin[3:0]);
                        crc_idx_d = 3'd0;
                        state_d   = ST_CRC;
                    end else begin
                        low_due = 1'b1;
                    end
                end
            end
            ST_CRC: begin
                if (sym_done) begin
                    if (crc_idx_q == 3'd7) begin
                        sym_d   = K_EOP;
                        state_d = ST_EOP;
                    end else begin
                        crc_idx_d = crc_idx_nxt;
                        sym_d     = nib_sym(crc_sh[3:0]);
                    end
                end
            end
            ST_EOP: begin
                if (sym_done) begin
                    en_d    = 1'b0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.phy_bmc_encoder_hold_lowbmc_done) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A low nibble is due: the next byte must already sit in the holding register.
        if (low_due) begin
            if (hold_vld_q) begin
                sym_d      = nib_sym(hold_dat_q[3:0]);
                cur_hi_d   = hold_dat_q[7:4];
                cur_last_d = hold_last_q;
                hold_vld_d = 1'b0;
                nib_hi_d   = 1'b0;
                state_d    = ST_DATA;
            end else begin
                en_d       = 1'b0;
                underrun_d = 1'b1;
                state_d    = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            type_q      <= 2'd0;
            os_idx_q    <= 2'd0;
            crc_idx_q   <= 3'd0;
            crc_q       <= CRC_INIT;
            hold_vld_q  <= 1'b0;
            hold_dat_q  <= 8'd0;
            hold_last_q <= 1'b0;
            last_acc_q  <= 1'b0;
            cur_hi_q    <= 4'd0;
            cur_last_q  <= 1'b0;
            nib_hi_q    <= 1'b0;
            sym_q       <= 5'd0;
            en_q        <= 1'b0;
            pre_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            os_idx_q    <= os_idx_d;
            crc_idx_q   <= crc_idx_d;
            crc_q       <= crc_d;
            hold_vld_q  <= hold_vld_d;
            hold_dat_q  <= hold_dat_d;
            hold_last_q <= hold_last_d;
            last_acc_q  <= last_acc_d;
            cur_hi_q    <= cur_hi_d;
            cur_last_q  <= cur_last_d;
            nib_hi_q    <= nib_hi_d;
            sym_q       <= sym_d;
            en_q        <= en_d;
            pre_q       <= pre_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.tx_byte_ready                 = byte_rdy;
    assign bus.tx_busy                       = busy_q;
    assign bus.tx_done                       = done_q;
    assign bus.tx_underrun                   = underrun_q;
    assign bus.phy_bmc_encoder_data          = sym_q;
    assign bus.phy_bmc_encoder_data_en       = en_q;
    assign bus.phy_bmc_encoder_data_preamble = pre_q;

endmodule

// File: tb/tb_phy_tx_sequencer.sv
// Directed bench for phy_tx_sequencer with a paced BMC encoder model and a byte feeder.
module tb_phy_tx_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    phy_tx_sequencer_if ifc();
    phy_tx_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    int checks = 0;
    int errors = 0;

    logic [5:0] log_q[$];
    logic [5:0] exp_q[$];
    logic [7:0] frame_bytes[$];
    logic [7:0] feed_q[$];
    bit         feed_last_mark;
    bit         fd_pend;
    int         acc_cnt, done_cnt, un_cnt;
    bit         rdy_seen;

    // Code tables written first-sent bit leftmost; rev5 turns them into bit0-first vectors.
    function automatic logic [4:0] rev5(input logic [4:0] s);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = s[4-i];
        return r;
    endfunction

    function automatic logic [4:0] nib_exp(input logic [3:0] n);
        logic [4:0] s;
        case (n)
            4'h0: s = 5'b11110;  4'h1: s = 5'b01001;  4'h2: s = 5'b10100;  4'h3: s = 5'b10101;
            4'h4: s = 5'b01010;  4'h5: s = 5'b01011;  4'h6: s = 5'b01110;  4'h7: s = 5'b01111;
            4'h8: s = 5'b10010;  4'h9: s = 5'b10011;  4'hA: s = 5'b10110;  4'hB: s = 5'b10111;
            4'hC: s = 5'b11010;  4'hD: s = 5'b11011;  4'hE: s = 5'b11100;  default: s = 5'b11101;
        endcase
        return rev5(s);
    endfunction

    function automatic logic [4:0] os_exp(input logic [1:0] t, input int i);
        logic [4:0] s1, s2, s3, r1, r2;
        s1 = rev5(5'b11000); s2 = rev5(5'b10001); s3 = rev5(5'b00110);
        r1 = rev5(5'b00111); r2 = rev5(5'b11001);
        case (t)
            2'd0:    return (i == 3) ? s2 : s1;
            2'd1:    return (i < 2) ? s1 : s3;
            2'd2:    return (i % 2 == 0) ? s1 : s3;
            default: return (i == 3) ? r2 : r1;
        endcase
    endfunction

    function automatic logic [31:0] crc_model();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (frame_bytes[k]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ frame_bytes[k][j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic build_exp(input logic [1:0] t, input bit tail, input logic [31:0] crc_fin);
        logic [31:0] c;
        exp_q.delete();
        exp_q.push_back(6'b100000);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, os_exp(t, i)});
        if (t != 2'd3) begin
            foreach (frame_bytes[k]) begin
                exp_q.push_back({1'b0, nib_exp(frame_bytes[k][3:0])});
                exp_q.push_back({1'b0, nib_exp(frame_bytes[k][7:4])});
            end
            if (tail) begin
                c = crc_fin;
                for (int k = 0; k < 8; k++) begin
                    exp_q.push_back({1'b0, nib_exp(c[3:0])});
                    c = c >> 4;
                end
                exp_q.push_back({1'b0, rev5(5'b01101)});
            end
        end
    endtask

    // Encoder model: data_done every 40 cycles of data_en (512 for the preamble), line release 24 after en falls.
    initial begin : encoder
        int   enc_cnt, hold_cnt;
        logic en_prev;
        enc_cnt = 0; hold_cnt = 0; en_prev = 1'b0;
        ifc.phy_bmc_encoder_data_done        = 1'b0;
        ifc.phy_bmc_encoder_hold_lowbmc_done = 1'b0;
        forever begin
            @(negedge clk);
            ifc.phy_bmc_encoder_data_done        = 1'b0;
            ifc.phy_bmc_encoder_hold_lowbmc_done = 1'b0;
            if (!rst_n) begin
                enc_cnt = 0; hold_cnt = 0; en_prev = 1'b0;
            end else begin
                if (ifc.phy_bmc_encoder_data_en) begin
                    enc_cnt++;
                    if (enc_cnt >= (ifc.phy_bmc_encoder_data_preamble ? 512 : 40)) begin
                        ifc.phy_bmc_encoder_data_done = 1'b1;
                        log_q.push_back({ifc.phy_bmc_encoder_data_preamble, ifc.phy_bmc_encoder_data});
                        enc_cnt = 0;
                    end
                end else begin
                    enc_cnt = 0;
                end
                if (en_prev && !ifc.phy_bmc_encoder_data_en) begin
                    hold_cnt = 24;
                end else if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) ifc.phy_bmc_encoder_hold_lowbmc_done = 1'b1;
                end
                en_prev = ifc.phy_bmc_encoder_data_en;
            end
        end
    end

    // Byte feeder: presents feed_q head; a handshake seen at negedge completes at the next posedge.
    initial begin : feeder
        ifc.tx_byte_valid = 1'b0; ifc.tx_byte = 8'd0; ifc.tx_byte_last = 1'b0;
        fd_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (fd_pend && feed_q.size() > 0) begin
                feed_q.delete(0);
                acc_cnt++;
            end
            if (feed_q.size() > 0) begin
                ifc.tx_byte_valid = 1'b1;
                ifc.tx_byte       = feed_q[0];
                ifc.tx_byte_last  = feed_last_mark && (feed_q.size() == 1);
            end else begin
                ifc.tx_byte_valid = 1'b0;
                ifc.tx_byte       = 8'd0;
                ifc.tx_byte_last  = 1'b0;
            end
            fd_pend = ifc.tx_byte_valid && ifc.tx_byte_ready;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (ifc.tx_done)       done_cnt++;
            if (ifc.tx_underrun)   un_cnt++;
            if (ifc.tx_byte_ready) rdy_seen = 1'b1;
        end
    end

    task automatic prep_frame(input logic [1:0] t, input bit last_mark);
        log_q.delete();
        done_cnt = 0; un_cnt = 0; acc_cnt = 0; rdy_seen = 1'b0;
        feed_last_mark = last_mark;
        feed_q = frame_bytes;
        @(negedge clk);
        ifc.tx_start = 1'b1; ifc.tx_sop_type = t;
        @(negedge clk);
        ifc.tx_start = 1'b0; ifc.tx_sop_type = 2'd0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (done_cnt != 0) begin ok = 1'b1; break; end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (log_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.tx_start = 1'b0; ifc.tx_sop_type = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifc.phy_bmc_encoder_data, ifc.phy_bmc_encoder_data_en, ifc.phy_bmc_encoder_data_preamble} !== 7'd0)
            begin errors++; $display("FAIL reset_symbol got %b want 0", {ifc.phy_bmc_encoder_data, ifc.phy_bmc_encoder_data_en, ifc.phy_bmc_encoder_data_preamble}); end
        checks++;
        if ({ifc.tx_busy, ifc.tx_done, ifc.tx_underrun, ifc.tx_byte_ready} !== 4'd0)
            begin errors++; $display("FAIL reset_status got %b want 0", {ifc.tx_busy, ifc.tx_done, ifc.tx_underrun, ifc.tx_byte_ready}); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        bit ok;
        frame_bytes.delete(); frame_bytes.push_back(8'hA1); frame_bytes.push_back(8'h61);
        prep_frame(2'd0, 1'b1);
        checks++;
        if (ifc.tx_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", ifc.tx_busy); end
        wait_done(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout got no tx_done want tx_done"); end
        build_exp(2'd0, 1'b1, crc_model());
        checks++;
        if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_sym[%0d] got %b want %b", i, log_q[i], exp_q[i]); end
        end
        checks++;
        if (done_cnt != 1 || ifc.tx_busy !== 1'b0 || ifc.phy_bmc_encoder_data_en !== 1'b0)
            begin errors++; $display("FAIL basic_end got done=%0d busy=%b en=%b want 1 0 0", done_cnt, ifc.tx_busy, ifc.phy_bmc_encoder_data_en); end
    endtask

    task automatic test_crc_check_value();
        bit ok;
        frame_bytes.delete();
        for (int i = 0; i < 9; i++) frame_bytes.push_back(8'h31 + 8'(i));
        prep_frame(2'd0, 1'b1);
        wait_done(4000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL crc_timeout got no tx_done want tx_done"); end
        build_exp(2'd0, 1'b1, 32'hCBF43926);
        checks++;
        if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL crc_len got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL crc_sym[%0d] got %b want %b", i, log_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_hard_reset();
        bit ok;
        frame_bytes.delete(); frame_bytes.push_back(8'h55);
        prep_frame(2'd3, 1'b1);
        wait_done(2000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hrst_timeout got no tx_done want tx_done"); end
        build_exp(2'd3, 1'b0, 32'd0);
        checks++;
        if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL hrst_len got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL hrst_sym[%0d] got %b want %b", i, log_q[i], exp_q[i]); end
        end
        checks++;
        if (rdy_seen || acc_cnt != 0) begin errors++; $display("FAIL hrst_ready got seen=%0d acc=%0d want 0 0", rdy_seen, acc_cnt); end
        checks++;
        if (ifc.phy_bmc_encoder_data_en !== 1'b0 || ifc.tx_busy !== 1'b0)
            begin errors++; $display("FAIL hrst_end got en=%b busy=%b want 0 0", ifc.phy_bmc_encoder_data_en, ifc.tx_busy); end
        feed_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_underrun();
        bit ok;
        frame_bytes.delete(); frame_bytes.push_back(8'h7E);
        prep_frame(2'd1, 1'b0);
        wait_done(2000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL undr_timeout got no tx_done want tx_done"); end
        build_exp(2'd1, 1'b0, 32'd0);
        checks++;
        if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL undr_len got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL undr_sym[%0d] got %b want %b", i, log_q[i], exp_q[i]); end
        end
        checks++;
        if (un_cnt != 1 || done_cnt != 1) begin errors++; $display("FAIL undr_pulses got underrun=%0d done=%0d want 1 1", un_cnt, done_cnt); end
        checks++;
        if (ifc.phy_bmc_encoder_data_en !== 1'b0) begin errors++; $display("FAIL undr_en got %b want 0", ifc.phy_bmc_encoder_data_en); end
    endtask

    task automatic test_restart_and_abort();
        bit ok;
        frame_bytes.delete(); frame_bytes.push_back(8'h5A); frame_bytes.push_back(8'h3C);
        prep_frame(2'd0, 1'b1);
        repeat (600) @(negedge clk);
        ifc.tx_start = 1'b1; ifc.tx_sop_type = 2'd3;
        @(negedge clk);
        ifc.tx_start = 1'b0; ifc.tx_sop_type = 2'd0;
        wait_log(7, 1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_timeout got %0d symbols want 7", log_q.size()); end
        build_exp(2'd0, 1'b0, 32'd0);
        for (int i = 0; i < 7 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL restart_sym[%0d] got %b want %b", i, log_q[i], exp_q[i]); end
        end
        checks++;
        if (ifc.phy_bmc_encoder_data_en !== 1'b1) begin errors++; $display("FAIL abort_pre_en got %b want 1", ifc.phy_bmc_encoder_data_en); end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({ifc.phy_bmc_encoder_data, ifc.phy_bmc_encoder_data_en, ifc.phy_bmc_encoder_data_preamble,
             ifc.tx_busy, ifc.tx_done, ifc.tx_underrun, ifc.tx_byte_ready} !== 11'd0)
            begin errors++; $display("FAIL abort_async got %b want 0", {ifc.phy_bmc_encoder_data, ifc.phy_bmc_encoder_data_en,
                  ifc.phy_bmc_encoder_data_preamble, ifc.tx_busy, ifc.tx_done, ifc.tx_underrun, ifc.tx_byte_ready}); end
        repeat (3) @(negedge clk);
        feed_q.delete();
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL abort_nodone got %0d want 0", done_cnt); end
        frame_bytes.delete(); frame_bytes.push_back(8'hC3);
        prep_frame(2'd0, 1'b1);
        wait_done(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL after_timeout got no tx_done want tx_done"); end
        build_exp(2'd0, 1'b1, crc_model());
        checks++;
        if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL after_len got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL after_sym[%0d] got %b want %b", i, log_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        frame_bytes.delete();
        frame_bytes.push_back(8'h00); frame_bytes.push_back(8'hFF); frame_bytes.push_back(8'h3C);
        prep_frame(2'd2, 1'b1);
        wait_log(6, 1500, ok);
        checks++;
        if (!ok || acc_cnt != 2) begin errors++; $display("FAIL b2b_drain got acc=%0d ok=%0d want acc=2 ok=1", acc_cnt, ok); end
        wait_done(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout got no tx_done want tx_done"); end
        build_exp(2'd2, 1'b1, crc_model());
        checks++;
        if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_sym[%0d] got %b want %b", i, log_q[i], exp_q[i]); end
        end
        checks++;
        if (acc_cnt != 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", acc_cnt); end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_cnt = 0; done_cnt = 0; un_cnt = 0; rdy_seen = 1'b0; feed_last_mark = 1'b0;
        test_reset();
        test_basic_frame();
        test_crc_check_value();
        test_hard_reset();
        test_underrun();
        test_restart_and_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
